// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, PC stack-op stall and load-use
// bubble insertion for a three-stage F / D / EM pipeline, with a saturating
// count of front-end stall cycles.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no multi-cycle operation in progress; new hazards evaluated
// LU_STALL | extra load-use bubble cycles; F/D held, D/EM flushed
// STACK    | PC push/pop occupying the memory port; F/D and D/EM held,
//          | cnt==0 is the release cycle

module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W      = 3,
  parameter int STACK_OP_CYCLES = 2,
  parameter int LOAD_USE_STALL  = 1,
  parameter int CNT_W           = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_branch_decision,
  input  logic                  i_push_pc,
  input  logic                  i_pop_pc,
  input  logic                  i_mem_read_em,
  input  logic [REG_ADDR_W-1:0] i_rd_em,
  input  logic [REG_ADDR_W-1:0] i_rs1_d,
  input  logic [REG_ADDR_W-1:0] i_rs2_d,
  input  logic                  i_rs1_used_d,
  input  logic                  i_rs2_used_d,
  output logic                  o_flush_f_d,
  output logic                  o_flush_d_em,
  output logic                  o_stall_f_d,
  output logic                  o_stall_d_em,
  output logic                  o_branch_decision,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_stall_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    STACK    = 2'd2
  } state_t;

  // Counter reload values; guarded so a parameter of 1 never goes negative.
  localparam int         STACK_INIT_I = (STACK_OP_CYCLES > 1) ? STACK_OP_CYCLES - 2 : 0;
  localparam int         LU_INIT_I    = (LOAD_USE_STALL > 1) ? LOAD_USE_STALL - 2 : 0;
  localparam logic [3:0] STACK_INIT   = 4'(STACK_INIT_I);
  localparam logic [3:0] LU_INIT      = 4'(LU_INIT_I);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use;
  logic             stack_op;

  assign load_use = i_mem_read_em &&
                    ((i_rs1_used_d && (i_rs1_d == i_rd_em)) ||
                     (i_rs2_used_d && (i_rs2_d == i_rd_em)));
  assign stack_op = i_push_pc | i_pop_pc;

  // State and down-counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and output decode; priority is reset > branch > stack > load-use.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    o_flush_f_d       = 1'b0;
    o_flush_d_em      = 1'b0;
    o_stall_f_d       = 1'b0;
    o_stall_d_em      = 1'b0;
    o_branch_decision = 1'b0;
    o_busy            = 1'b0;

    if (i_reset) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      o_busy = (state != IDLE);
      if (i_branch_decision) begin
        o_flush_f_d       = 1'b1;
        o_flush_d_em      = 1'b1;
        o_branch_decision = 1'b1;
        state_nxt         = IDLE;
        cnt_nxt           = '0;
      end else begin
        case (state)
          IDLE: begin
            if (stack_op) begin
              // A single-cycle stack op fits in the normal EM slot.
              if (STACK_OP_CYCLES > 1) begin
                o_stall_f_d  = 1'b1;
                o_stall_d_em = 1'b1;
                state_nxt    = STACK;
                cnt_nxt      = STACK_INIT;
              end
            end else if (load_use) begin
              o_stall_f_d  = 1'b1;
              o_flush_d_em = 1'b1;
              if (LOAD_USE_STALL > 1) begin
                state_nxt = LU_STALL;
                cnt_nxt   = LU_INIT;
              end
            end
          end
          LU_STALL: begin
            o_stall_f_d  = 1'b1;
            o_flush_d_em = 1'b1;
            if (cnt != 4'd0) begin
              cnt_nxt = cnt - 4'd1;
            end else begin
              state_nxt = IDLE;
            end
          end
          STACK: begin
            if (cnt != 4'd0) begin
              o_stall_f_d  = 1'b1;
              o_stall_d_em = 1'b1;
              cnt_nxt      = cnt - 4'd1;
            end else begin
              // Release cycle: the same push/pop is still in EM, do not restart.
              state_nxt = IDLE;
            end
          end
          default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  // Saturating count of cycles in which the front end was held.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt <= '0;
    end else if (o_stall_f_d && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Reset forces every output low in the same cycle, including the count.
  assign o_stall_count = i_reset ? '0 : stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: two differently parameterised
// instances share one stimulus stream; a behavioural model pushes the expected
// outputs of every cycle into a scoreboard that is popped against the DUTs.

module tb_pipeline_hazard_ctrl;

  localparam int SOC_A = 3;
  localparam int LUS_A = 2;
  localparam int CW_A  = 16;
  localparam int SOC_B = 4;
  localparam int LUS_B = 1;
  localparam int CW_B  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       br = 1'b0, push = 1'b0, pop = 1'b0, mr = 1'b0;
  logic [2:0] rd = '0, rs1 = '0, rs2 = '0;
  logic       u1 = 1'b0, u2 = 1'b0;

  logic            ffd_a, fdem_a, sfd_a, sdem_a, br_a, busy_a;
  logic [CW_A-1:0] cnt_a;
  logic            ffd_b, fdem_b, sfd_b, sdem_b, br_b, busy_b;
  logic [CW_B-1:0] cnt_b;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(3), .STACK_OP_CYCLES(SOC_A),
                         .LOAD_USE_STALL(LUS_A), .CNT_W(CW_A)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_branch_decision(br),
    .i_push_pc(push), .i_pop_pc(pop), .i_mem_read_em(mr), .i_rd_em(rd),
    .i_rs1_d(rs1), .i_rs2_d(rs2), .i_rs1_used_d(u1), .i_rs2_used_d(u2),
    .o_flush_f_d(ffd_a), .o_flush_d_em(fdem_a), .o_stall_f_d(sfd_a),
    .o_stall_d_em(sdem_a), .o_branch_decision(br_a), .o_busy(busy_a),
    .o_stall_count(cnt_a));

  pipeline_hazard_ctrl #(.REG_ADDR_W(3), .STACK_OP_CYCLES(SOC_B),
                         .LOAD_USE_STALL(LUS_B), .CNT_W(CW_B)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_branch_decision(br),
    .i_push_pc(push), .i_pop_pc(pop), .i_mem_read_em(mr), .i_rd_em(rd),
    .i_rs1_d(rs1), .i_rs2_d(rs2), .i_rs1_used_d(u1), .i_rs2_used_d(u2),
    .o_flush_f_d(ffd_b), .o_flush_d_em(fdem_b), .o_stall_f_d(sfd_b),
    .o_stall_d_em(sdem_b), .o_branch_decision(br_b), .o_busy(busy_b),
    .o_stall_count(cnt_b));

  typedef struct packed {
    logic [5:0]  flags;   // {flush_f_d, flush_d_em, stall_f_d, stall_d_em, branch, busy}
    logic [31:0] count;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: mode 0 idle, 1 load-use, 2 stack; left = cycles still to spend in mode.
  int m_mode[2];
  int m_left[2];
  int m_cnt[2];
  int p_soc[2];
  int p_lus[2];
  int p_max[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input int k, output exp_t e);
    logic ffd, fdem, sfd, sdem, bro, bsy, haz;
    ffd = 0; fdem = 0; sfd = 0; sdem = 0; bro = 0; bsy = 0;
    haz = mr && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (rst) begin
      e.count   = 0;
      m_mode[k] = 0;
      m_left[k] = 0;
      m_cnt[k]  = 0;
    end else begin
      e.count = m_cnt[k];
      bsy     = (m_mode[k] != 0);
      if (br) begin
        ffd = 1; fdem = 1; bro = 1;
        m_mode[k] = 0;
        m_left[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (push || pop) begin
          if (p_soc[k] > 1) begin
            sfd = 1; sdem = 1;
            m_mode[k] = 2;
            m_left[k] = p_soc[k] - 1;
          end
        end else if (haz) begin
          sfd = 1; fdem = 1;
          if (p_lus[k] > 1) begin
            m_mode[k] = 1;
            m_left[k] = p_lus[k] - 1;
          end
        end
      end else if (m_mode[k] == 1) begin
        sfd = 1; fdem = 1;
        m_left[k]--;
        if (m_left[k] == 0) m_mode[k] = 0;
      end else begin
        if (m_left[k] > 1) begin
          sfd = 1; sdem = 1;
        end
        m_left[k]--;
        if (m_left[k] == 0) m_mode[k] = 0;
      end
      if (sfd && m_cnt[k] < p_max[k]) m_cnt[k]++;
    end
    e.flags = {ffd, fdem, sfd, sdem, bro, bsy};
  endtask

  task automatic drive_cycle(input logic r, input logic b, input logic pu, input logic po,
                             input logic m, input logic [2:0] d, input logic [2:0] s1,
                             input logic [2:0] s2, input logic v1, input logic v2);
    exp_t ea, eb, got;
    @(negedge clk);
    rst = r; br = b; push = pu; pop = po; mr = m;
    rd = d; rs1 = s1; rs2 = s2; u1 = v1; u2 = v2;
    #1;
    model_step(0, ea);
    model_step(1, eb);
    sb_q.push_back(ea);
    sb_q.push_back(eb);
    got = sb_q.pop_front();
    check_val("flags_a", {26'd0, ffd_a, fdem_a, sfd_a, sdem_a, br_a, busy_a}, {26'd0, got.flags});
    check_val("count_a", 32'(cnt_a), got.count);
    got = sb_q.pop_front();
    check_val("flags_b", {26'd0, ffd_b, fdem_b, sfd_b, sdem_b, br_b, busy_b}, {26'd0, got.flags});
    check_val("count_b", 32'(cnt_b), got.count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
  endtask

  initial begin
    p_soc[0] = SOC_A; p_lus[0] = LUS_A; p_max[0] = (1 << CW_A) - 1;
    p_soc[1] = SOC_B; p_lus[1] = LUS_B; p_max[1] = (1 << CW_B) - 1;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
    end

    do_reset(2);
    idle(2);

    // Push: A holds 2 cycles then releases, B holds 3 then releases.
    drive_cycle(0, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    idle(5);
    drive_cycle(0, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    idle(5);

    // Load-use on rs2: A inserts two bubbles, B one.
    do_reset(1);
    drive_cycle(0, 0, 0, 0, 1, 3'd3, 3'd0, 3'd3, 0, 1);
    idle(2);
    check_val("lu_count_a", 32'(cnt_a), 32'd2);
    check_val("lu_count_b", 32'(cnt_b), 32'd1);

    // Same registers but rs2 not read: no hazard.
    drive_cycle(0, 0, 0, 0, 1, 3'd3, 3'd0, 3'd3, 0, 0);
    idle(1);
    check_val("nohaz_count_a", 32'(cnt_a), 32'd2);

    // Hazard on rs1, plus push+hazard together (stack op wins).
    drive_cycle(0, 0, 0, 0, 1, 3'd5, 3'd5, 3'd1, 1, 0);
    idle(3);
    drive_cycle(0, 0, 1, 0, 1, 3'd2, 3'd2, 3'd2, 1, 1);
    idle(5);

    // Branch in the second STACK cycle.
    drive_cycle(0, 0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
    idle(1);
    drive_cycle(0, 1, 1, 0, 1, 3'd1, 3'd1, 3'd1, 1, 1);
    idle(1);
    check_val("br_busy_b", {31'd0, busy_b}, 32'd0);
    idle(2);

    // Reset during LU_STALL.
    drive_cycle(0, 0, 0, 0, 1, 3'd4, 3'd4, 3'd0, 1, 0);
    do_reset(1);
    idle(2);

    // Continuous stalling: B saturates at 3.
    for (int i = 0; i < 6; i++) drive_cycle(0, 0, 0, 0, 1, 3'd6, 3'd6, 3'd6, 1, 1);
    idle(1);
    check_val("sat_b", 32'(cnt_b), 32'd3);
    check_val("nosat_a", 32'(cnt_a), 32'd6);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive_cycle(($urandom_range(29) == 0), ($urandom_range(9) == 0),
                  ($urandom_range(7) == 0), ($urandom_range(9) == 0),
                  1'($urandom_range(1)), 3'($urandom_range(3)), 3'($urandom_range(3)),
                  3'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
